// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types and constants for the ALU reservation station.
// Holds operand/entry/CDB structs, widths, opcode encodings and the
// CDB snoop helper shared by dispatch bypass and entry wakeup.
package alu_rs_scheduler_pkg;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd0;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd1;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd2;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd5;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd6;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd7;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd8;
  localparam logic [OP_W-1:0] OP_OR    = 6'd9;
  localparam logic [OP_W-1:0] OP_AND   = 6'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd11;

  typedef struct packed {
    logic             busy;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } operand_t;

  typedef struct packed {
    logic             valid;
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } cdb_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [ROB_W-1:0] rd;
    operand_t         j;
    operand_t         k;
  } rs_entry_t;

  // Capture a pending operand from the CDBs; cdb0 has priority.
  function automatic operand_t snoop(input operand_t o, input cdb_t c0, input cdb_t c1);
    operand_t r;
    r = o;
    if (o.busy && c0.valid && c0.tag == o.tag) begin
      r.busy = FALSE;
      r.val  = c0.value;
    end else if (o.busy && c1.valid && c1.tag == o.tag) begin
      r.busy = FALSE;
      r.val  = c1.value;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB snoop and ALU issue bundle of the reservation station.
// master: front end / testbench side; slave: the reservation station.
interface alu_rs_scheduler_if;
  import alu_rs_scheduler_pkg::*;

  logic             disp_valid;
  logic [OP_W-1:0]  disp_op;
  logic [XLEN-1:0]  disp_pc, disp_imm;
  logic [ROB_W-1:0] disp_rd_rename;
  logic             disp_qj_busy, disp_qk_busy;
  logic [ROB_W-1:0] disp_qj, disp_qk;
  logic [XLEN-1:0]  disp_vj, disp_vk;

  logic             cdb0_valid, cdb1_valid;
  logic [ROB_W-1:0] cdb0_tag, cdb1_tag;
  logic [XLEN-1:0]  cdb0_value, cdb1_value;

  logic             rs_full;
  logic             alu_enable;
  logic [OP_W-1:0]  alu_op;
  logic [XLEN-1:0]  alu_pc, alu_imm, alu_rs1_value, alu_rs2_value;
  logic [ROB_W-1:0] alu_rd_rename;

  modport master (
    output disp_valid, disp_op, disp_pc, disp_imm, disp_rd_rename,
           disp_qj_busy, disp_qk_busy, disp_qj, disp_qk, disp_vj, disp_vk,
           cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_value, cdb1_value,
    input  rs_full, alu_enable, alu_op, alu_pc, alu_imm,
           alu_rs1_value, alu_rs2_value, alu_rd_rename
  );

  modport slave (
    input  disp_valid, disp_op, disp_pc, disp_imm, disp_rd_rename,
           disp_qj_busy, disp_qk_busy, disp_qj, disp_qk, disp_vj, disp_vk,
           cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_value, cdb1_value,
    output rs_full, alu_enable, alu_op, alu_pc, alu_imm,
           alu_rs1_value, alu_rs2_value, alu_rd_rename
  );
endinterface

// File: rtl/alu_rs_scheduler_rs_age_select.sv
// Age matrix and oldest-ready selector.
// Ports: clk/rst_n; alloc_en/alloc_idx mark a new entry youngest; valid is
// the pre-edge occupancy; ready selects candidates; sel_any/sel_oh/sel_idx
// give the oldest ready entry (combinational).
module rs_age_select #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en,
  input  logic [IW-1:0]    alloc_idx,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  output logic             sel_any,
  output logic [DEPTH-1:0] sel_oh,
  output logic [IW-1:0]    sel_idx
);
  // age[i][j] = 1: entry i is older than entry j
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [DEPTH-1:0]            blocked;

  // New entry is younger than everything valid. Its own diagonal bit is
  // written 0 by both loops since a free slot is never valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (alloc_en) begin
      for (int i = 0; i < DEPTH; i++) age[alloc_idx][i] <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age[i][alloc_idx] <= valid[i];
    end
  end

  // An entry is blocked when some older entry is also ready; for any two
  // valid entries exactly one direction is set, so the winner is unique.
  always_comb begin
    blocked = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        blocked[i] = blocked[i] | (ready[j] & age[j][i]);
    sel_oh = ready & ~blocked;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_idx = IW'(i);
    sel_any = |sel_oh;
  end
endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station + oldest-first issue scheduler for the integer ALU.
// Ports: clk, rst_n (async low), rdy (freeze when low), jump_wrong (flush),
// rs (slave bundle: dispatch in, two CDB snoop ports in, rs_full and the
// registered ALU issue bundle out).
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  input logic               rdy,
  input logic               jump_wrong,
  alu_rs_scheduler_if.slave rs
);
  localparam int IW = $clog2(DEPTH);

  rs_entry_t        ent     [DEPTH];
  rs_entry_t        ent_nxt [DEPTH];
  logic [DEPTH-1:0] valid, valid_nxt, ready, sel_oh;
  logic [IW-1:0]    free_idx, sel_idx;
  logic             sel_any, accept;
  cdb_t             c0, c1;
  operand_t         dj, dk;

  assign c0     = '{valid: rs.cdb0_valid, tag: rs.cdb0_tag, value: rs.cdb0_value};
  assign c1     = '{valid: rs.cdb1_valid, tag: rs.cdb1_tag, value: rs.cdb1_value};
  assign dj     = '{busy: rs.disp_qj_busy, tag: rs.disp_qj, val: rs.disp_vj};
  assign dk     = '{busy: rs.disp_qk_busy, tag: rs.disp_qk, val: rs.disp_vk};
  assign accept = rs.disp_valid & ~rs.rs_full;

  // Readiness looks only at registered state, so a write becomes issuable
  // one edge later at the earliest.
  always_comb
    for (int i = 0; i < DEPTH; i++)
      ready[i] = valid[i] & ~ent[i].j.busy & ~ent[i].k.busy;

  // Lowest free slot from pre-edge occupancy: a slot freed by this edge's
  // issue is not reused until the next edge.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IW'(i);
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (accept & rdy & ~jump_wrong),
    .alloc_idx (free_idx),
    .valid     (valid),
    .ready     (ready),
    .sel_any   (sel_any),
    .sel_oh    (sel_oh),
    .sel_idx   (sel_idx)
  );

  always_comb begin
    valid_nxt = valid & ~sel_oh;
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i]   = ent[i];
      ent_nxt[i].j = snoop(ent[i].j, c0, c1);
      ent_nxt[i].k = snoop(ent[i].k, c0, c1);
    end
    if (accept) begin
      valid_nxt[free_idx]   = TRUE;
      ent_nxt[free_idx].op  = rs.disp_op;
      ent_nxt[free_idx].pc  = rs.disp_pc;
      ent_nxt[free_idx].imm = rs.disp_imm;
      ent_nxt[free_idx].rd  = rs.disp_rd_rename;
      ent_nxt[free_idx].j   = snoop(dj, c0, c1);
      ent_nxt[free_idx].k   = snoop(dk, c0, c1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid            <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      rs.rs_full       <= FALSE;
      rs.alu_enable    <= FALSE;
      rs.alu_op        <= '0;
      rs.alu_pc        <= '0;
      rs.alu_imm       <= '0;
      rs.alu_rs1_value <= '0;
      rs.alu_rs2_value <= '0;
      rs.alu_rd_rename <= '0;
    end else if (jump_wrong) begin
      valid         <= '0;
      rs.alu_enable <= FALSE;
      rs.rs_full    <= FALSE;
    end else if (rdy) begin
      valid         <= valid_nxt;
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      rs.rs_full    <= &valid_nxt;
      rs.alu_enable <= sel_any;
      // buses keep the last issued op when nothing is selected
      if (sel_any) begin
        rs.alu_op        <= ent[sel_idx].op;
        rs.alu_pc        <= ent[sel_idx].pc;
        rs.alu_imm       <= ent[sel_idx].imm;
        rs.alu_rs1_value <= ent[sel_idx].j.val;
        rs.alu_rs2_value <= ent[sel_idx].k.val;
        rs.alu_rd_rename <= ent[sel_idx].rd;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: a queue-based reference model
// (entries kept in dispatch order) pushes expected issues; a monitor on the
// falling edge pops and compares whatever the DUT issues.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0, jump_wrong = 1'b0;
  always #5 clk = ~clk;

  alu_rs_scheduler_if rs_if ();
  alu_rs_scheduler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .jump_wrong (jump_wrong),
    .rs         (rs_if)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  pc, imm, v1, v2;
    logic [ROB_W-1:0] rd, t1, t2;
    bit               b1, b2;
  } mop_t;

  mop_t mq[$];     // model contents, oldest at front
  mop_t exp_q[$];  // expected issue stream
  mop_t m, e, last;
  bit   exp_en = 0, exp_full = 0, edge_active = 0, edge_hold = 0, done = 0;
  int   pre = 0, checks = 0, failures = 0, issued = 0;

  function automatic mop_t wake(input mop_t x);
    mop_t r = x;
    if (r.b1 && rs_if.cdb0_valid && rs_if.cdb0_tag == r.t1) begin r.b1 = 0; r.v1 = rs_if.cdb0_value; end
    else if (r.b1 && rs_if.cdb1_valid && rs_if.cdb1_tag == r.t1) begin r.b1 = 0; r.v1 = rs_if.cdb1_value; end
    if (r.b2 && rs_if.cdb0_valid && rs_if.cdb0_tag == r.t2) begin r.b2 = 0; r.v2 = rs_if.cdb0_value; end
    else if (r.b2 && rs_if.cdb1_valid && rs_if.cdb1_tag == r.t2) begin r.b2 = 0; r.v2 = rs_if.cdb1_value; end
    return r;
  endfunction

  function automatic string fmt(input mop_t x);
    return $sformatf("op=%0h pc=%h imm=%h rs1=%h rs2=%h rd=%0h", x.op, x.pc, x.imm, x.v1, x.v2, x.rd);
  endfunction

  function automatic string dut_fmt();
    return $sformatf("op=%0h pc=%h imm=%h rs1=%h rs2=%h rd=%0h", rs_if.alu_op, rs_if.alu_pc,
                     rs_if.alu_imm, rs_if.alu_rs1_value, rs_if.alu_rs2_value, rs_if.alu_rd_rename);
  endfunction

  function automatic bit bus_eq(input mop_t x);
    return rs_if.alu_op === x.op && rs_if.alu_pc === x.pc && rs_if.alu_imm === x.imm &&
           rs_if.alu_rs1_value === x.v1 && rs_if.alu_rs2_value === x.v2 && rs_if.alu_rd_rename === x.rd;
  endfunction

  // Reference model: one step per active edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    edge_active = 0;
    edge_hold   = 0;
    if (!rst_n) begin
      mq.delete(); exp_q.delete(); exp_en = 0; exp_full = 0;
    end else if (jump_wrong) begin
      mq.delete(); exp_en = 0; exp_full = 0;
    end else if (!rdy) begin
      edge_hold = 1;
    end else begin
      edge_active = 1;
      pre    = mq.size();
      exp_en = 0;
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].b1 && !mq[i].b2) begin
          exp_q.push_back(mq[i]); mq.delete(i); exp_en = 1; break;
        end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (rs_if.disp_valid && pre < DEPTH) begin
        m.op = rs_if.disp_op; m.pc = rs_if.disp_pc; m.imm = rs_if.disp_imm; m.rd = rs_if.disp_rd_rename;
        m.b1 = rs_if.disp_qj_busy; m.t1 = rs_if.disp_qj; m.v1 = rs_if.disp_vj;
        m.b2 = rs_if.disp_qk_busy; m.t2 = rs_if.disp_qk; m.v2 = rs_if.disp_vk;
        mq.push_back(wake(m));
      end
      exp_full = (mq.size() == DEPTH);
    end
  end

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=(%s) required=(%s)", name, act, req);
    end
  endtask

  // Monitor / scoreboard checker.
  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk({rs_if.alu_enable, rs_if.rs_full} === 2'b00 && rs_if.alu_op === '0 && rs_if.alu_pc === '0 &&
          rs_if.alu_imm === '0 && rs_if.alu_rs1_value === '0 && rs_if.alu_rs2_value === '0 &&
          rs_if.alu_rd_rename === '0, "reset_outputs",
          $sformatf("en=%b full=%b %s", rs_if.alu_enable, rs_if.rs_full, dut_fmt()), "all zero");
    end else if (done) begin
      chk(exp_q.size() == 0, "scoreboard_drain", $sformatf("%0d pending", exp_q.size()), "0 pending");
      chk(issued > 20, "issue_count", $sformatf("%0d", issued), ">20");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else begin
      chk(rs_if.alu_enable === exp_en, "alu_enable", $sformatf("%b", rs_if.alu_enable), $sformatf("%b", exp_en));
      chk(rs_if.rs_full === exp_full, "rs_full", $sformatf("%b", rs_if.rs_full), $sformatf("%b", exp_full));
      if (edge_active && rs_if.alu_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "issue_unexpected", dut_fmt(), "no issue");
        end else begin
          e = exp_q.pop_front();
          issued++;
          chk(bus_eq(e), "issue_bundle", dut_fmt(), fmt(e));
          last = e;
        end
      end else if (edge_hold && rs_if.alu_enable === 1'b1) begin
        chk(bus_eq(last), "hold_bundle", dut_fmt(), fmt(last));
      end
    end
  end

  // Stimulus: inputs change 1 time unit after the falling edge.
  task automatic tick(); @(negedge clk); #1; endtask

  task automatic clr();
    rs_if.disp_valid = 0; rs_if.cdb0_valid = 0; rs_if.cdb1_valid = 0; jump_wrong = 0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [ROB_W-1:0] rd,
                          input bit jb, input logic [ROB_W-1:0] qj, input logic [XLEN-1:0] vj,
                          input bit kb, input logic [ROB_W-1:0] qk, input logic [XLEN-1:0] vk);
    rs_if.disp_valid = 1; rs_if.disp_op = op; rs_if.disp_pc = $urandom; rs_if.disp_imm = $urandom;
    rs_if.disp_rd_rename = rd;
    rs_if.disp_qj_busy = jb; rs_if.disp_qj = qj; rs_if.disp_vj = vj;
    rs_if.disp_qk_busy = kb; rs_if.disp_qk = qk; rs_if.disp_vk = vk;
  endtask

  task automatic set_cdb(input int port, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val);
    if (port == 0) begin rs_if.cdb0_valid = 1; rs_if.cdb0_tag = tag; rs_if.cdb0_value = val; end
    else           begin rs_if.cdb1_valid = 1; rs_if.cdb1_tag = tag; rs_if.cdb1_value = val; end
  endtask

  initial begin
    clr();
    set_disp(OP_ADD, 0, 0, 0, 0, 0, 0, 0);
    rs_if.disp_valid = 0;
    set_cdb(0, 0, 0); set_cdb(1, 0, 0); clr();
    rdy = 1;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // single ready ADD
    set_disp(OP_ADD, 3, 0, 0, 5, 0, 0, 7); tick(); clr(); repeat (3) tick();

    // A waits on tag 2, B ready: B first, then A after cdb1 wakeup
    set_disp(OP_ADD, 4, 1, 2, 0, 0, 0, 1); tick();
    set_disp(OP_SUB, 5, 0, 0, 3, 0, 0, 4); tick(); clr(); tick();
    set_cdb(1, 2, 32'h10); tick(); clr(); repeat (3) tick();

    // fill all entries waiting on tag 9; ninth dispatch hits rs_full
    for (int i = 0; i < 9; i++) begin
      set_disp(OP_ADDI, ROB_W'(i), 1, 9, 0, 0, 0, XLEN'(i)); tick();
    end
    clr(); tick();
    set_cdb(0, 9, 1); tick(); clr(); repeat (10) tick();

    // dispatch bypass on rs2
    set_disp(OP_XOR, 6, 0, 0, 1, 1, 5, 0); set_cdb(0, 5, 32'hAA); tick(); clr(); repeat (3) tick();

    // flush with 3 valid entries and a pending issue
    for (int i = 0; i < 2; i++) begin set_disp(OP_BEQ, ROB_W'(i), 1, 11, 0, 0, 0, 0); tick(); end
    for (int i = 0; i < 3; i++) begin set_disp(OP_OR, ROB_W'(i + 2), 0, 0, 9, 0, 0, 8); tick(); end
    set_disp(OP_AND, 7, 0, 0, 1, 0, 0, 2); jump_wrong = 1; tick(); clr(); repeat (2) tick();
    set_cdb(0, 11, 32'h55); tick(); clr();
    set_disp(OP_LUI, 0, 0, 0, 0, 0, 0, 0); tick(); clr(); repeat (3) tick();

    // freeze while an issue is pending
    set_disp(OP_JAL, 8, 0, 0, 32'h123, 0, 0, 32'h456); tick(); clr(); tick();
    rdy = 0;
    set_disp(OP_ADD, 9, 0, 0, 1, 0, 0, 1); repeat (3) tick(); clr();
    rdy = 1; repeat (3) tick();

    // randomized traffic with a mid-run async reset
    for (int c = 0; c < 600; c++) begin
      clr();
      rdy        = ($urandom_range(0, 7) != 0);
      jump_wrong = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0)
        set_disp(OP_W'($urandom_range(0, 11)), ROB_W'($urandom), $urandom_range(0, 1) == 1,
                 ROB_W'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
                 ROB_W'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) set_cdb(0, ROB_W'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 1) == 1) set_cdb(1, ROB_W'($urandom_range(0, 7)), $urandom);
      if (c == 300) begin
        @(posedge clk); #2; rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
      end
      tick();
    end

    // drain: wake every tag used by the random phase
    clr(); rdy = 1;
    for (int t = 0; t < 8; t++) begin set_cdb(0, ROB_W'(t), $urandom); tick(); end
    clr(); repeat (12) tick();
    done = 1;
    repeat (3) tick();
  end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler in front of the single integer ALU.
- Buffers dispatched ALU/branch/jump ops and snoops two CDB broadcast ports (ALU result, load/store result) to wake pending operands.
- Issues at most one ready op per cycle, oldest first, as registered ALU-enable plus operand bundle.
- Cleared completely on branch mispredict.

Parameters:
- DEPTH, 8, number of RS entries (power of 2, >=2)
- ROB_W, 4, ROB rename tag width
- OP_W, 6, opcode enum width (shared package)
- XLEN, 32, data/address/immediate width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low = freeze all state and outputs
- jump_wrong  in  1  mispredict flush
- disp_valid  in  1  dispatch request
- disp_op  in  OP_W  opcode
- disp_pc  in  XLEN  instruction PC
- disp_imm  in  XLEN  sign-extended immediate
- disp_rd_rename  in  ROB_W  destination ROB tag
- disp_qj_busy, disp_qk_busy  in  1 each  rs1/rs2 operand still pending
- disp_qj, disp_qk  in  ROB_W each  producer tags when busy
- disp_vj, disp_vk  in  XLEN each  operand values when not busy
- cdb0_valid, cdb1_valid  in  1 each  broadcast valid (ALU, LSB)
- cdb0_tag, cdb1_tag  in  ROB_W each  broadcast tag
- cdb0_value, cdb1_value  in  XLEN each  broadcast data
- rs_full  out  1  registered; no free entry
- alu_enable  out  1  issue strobe to ALU
- alu_op  out  OP_W
- alu_pc  out  XLEN
- alu_imm  out  XLEN
- alu_rs1_value, alu_rs2_value  out  XLEN each
- alu_rd_rename  out  ROB_W

Behaviour:
- Reset (rst_n=0, async): all entry valid bits 0, age matrix 0, every output 0 (rs_full=0, alu_enable=0, all buses 0).
- Priority per rising edge, highest first: reset, jump_wrong, !rdy, normal.
- jump_wrong=1, independent of rdy: all valid 0, alu_enable<=0, rs_full<=0; same-cycle dispatch dropped.
- rdy=0: all state and outputs hold, including a pending alu_enable=1. The ALU samples that strobe on the next rdy=1 edge, so the op executes exactly once.
- Dispatch, accepted when disp_valid & !rs_full:
  - write lowest-index free entry.
  - ignored when rs_full=1; no error flag.
- Dispatch bypass: if disp_qj_busy and a valid CDB tag equals disp_qj in the same cycle, store value as ready. Same for qk. cdb0 wins if both CDBs match.
- Wakeup: each valid busy operand whose tag matches a valid CDB tag latches that value and clears busy. Both operands of one entry may wake in the same cycle from different CDBs.
- Ready entry = valid & !qj_busy & !qk_busy.
- Readiness is evaluated on registered state only. A dispatched or woken entry is issuable at the earliest one cycle after the write: dispatch at edge N, alu_enable=1 after edge N+1.
- Age matrix: age[i][j]=1 means i is older than j.
  - On alloc of k: row k cleared; column k set for every currently valid entry.
- Select: ready entry i with no ready j where age[j][i]=1. Unique by construction. Combinational select, registered issue.
- Issue at edge with rdy=1:
  - alu_enable<=1 and outputs <= selected entry fields; entry valid<=0.
  - If none ready: alu_enable<=0, buses hold last values.
- Freed entry is not reusable by a dispatch in the same edge (free index computed from pre-edge valid).
- rs_full <= (next-state valid count == DEPTH). An issue and a dispatch in the same edge keep the count unchanged.
- Ops with no register sources (LUI, AUIPC, JAL) arrive with both busy=0 and are handled identically.
- Tag 0 is a legal ROB tag; no special casing.

Decomposition:
- Shared package: OP_W and opcode localparams, ROB_W, XLEN, TRUE/FALSE.
- One natural sub-module: rs_age_select, holding the age matrix update plus oldest-ready one-hot/index encoder. Parameterised by DEPTH; purely combinational select plus matrix register.
- Entry storage, wakeup and free-slot priority encoder stay in the top.

Test Plan:
- Ready dispatch: ADD, vj=5, vk=7, rd=3, no busy, at edge 1 -> alu_enable=1 after edge 2, rs1=5, rs2=7, rd_rename=3; alu_enable=0 after edge 3.
- Wakeup order: dispatch A (qj=2 busy), then B (ready). -> B issues first. cdb1 tag2=0x10 -> A issues next cycle with rs1=0x10.
- Oldest-first: fill all 8 entries, each waiting on tag 9; cdb0 tag9=1 -> 8 consecutive issues in dispatch order; rs_full drops after the first issue edge.
- Full plus bypass: 9th dispatch while rs_full=1 is ignored (8 issues only). A dispatch with qk=5 busy coinciding with cdb0 tag5=0xAA -> issued next cycle with rs2=0xAA.
- Flush: 3 entries valid, pending alu_enable=1, jump_wrong pulse -> alu_enable=0 next edge, no further issues, rs_full=0; a subsequent dispatch issues normally.
- rdy/reset: rdy held low 3 cycles with alu_enable=1 -> outputs stable, no second issue when rdy returns. rst_n low mid-operation -> all outputs 0 immediately without a clock edge.
